// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - display word, button and 7-segment signal bundle
interface seg7_scan_ctrl_if;
    logic [15:0] disp;
    logic        btn_next;
    logic        btn_prev;
    logic        hold;
    logic [3:0]  show;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output disp, btn_next, btn_prev, hold,
        input  show, an, seg, dp
    );

    modport slave (
        input  disp, btn_next, btn_prev, hold,
        output show, an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit 7-segment scanner with debounced register-select buttons
module seg7_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC);

    // index 0 = next button, index 1 = prev button
    logic [1:0]         sync1_q, sync2_q, stable_q, armed_q;
    logic [1:0]         stable_d, armed_d, rise;
    logic [1:0]         fill_q, fill_d;
    logic [1:0][DW-1:0] dbc_q, dbc_d;

    logic [3:0]    show_q, show_d;
    logic [15:0]   snap_q, snap_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    nib;

    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // A button only produces a press pulse once it has been seen released after
    // reset; fill_q marks when the synchronisers hold real post-reset samples.
    always_comb begin
        stable_d = stable_q;
        armed_d  = armed_q | ({2{fill_q[1]}} & ~sync2_q);
        rise     = 2'b00;
        dbc_d    = '0;
        fill_d   = {fill_q[0], 1'b1};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (dbc_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    stable_d[i] = sync2_q[i];
                    rise[i]     = sync2_q[i] & armed_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        show_d = show_q;
        case (rise)
            2'b01:   show_d = show_q + 4'd1;
            2'b10:   show_d = show_q - 4'd1;
            default: show_d = show_q;
        endcase

        snap_d = bus.hold ? snap_q : bus.disp;

        rcnt_d = rcnt_q + RW'(1);
        idx_d  = idx_q;
        if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end

        nib   = snap_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hexdec(nib);
        dp_d  = ~((idx_q == 2'd3) & bus.hold);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            armed_q  <= '0;
            fill_q   <= '0;
            dbc_q    <= '0;
            show_q   <= '0;
            snap_q   <= '0;
            rcnt_q   <= '0;
            idx_q    <= '0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            sync1_q  <= {bus.btn_prev, bus.btn_next};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            fill_q   <= fill_d;
            dbc_q    <= dbc_d;
            show_q   <= show_d;
            snap_q   <= snap_d;
            rcnt_q   <= rcnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.show = show_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam int RD  = 4;
    localparam int DEB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .DEBOUNCE_CYC(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] an_lit  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_lit [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once the last DEB synchronised samples all
    // disagree with the accepted level; digit index follows from elapsed cycles.
    bit         m_valid = 1'b0;
    int         m_since;
    bit         m_stable [2];
    bit         m_armed  [2];
    bit         m_samp   [2][DEB+1];
    logic [3:0] m_show;
    logic [15:0] m_snap;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    always @(posedge clk) begin
        bit btn   [2];
        bit acc   [2];
        bit pulse [2];
        int idx;
        btn[0] = bus.btn_next;
        btn[1] = bus.btn_prev;
        if (!rst) begin
            m_valid = 1'b1;
            m_since = 0;
            m_show  = 4'h0;
            m_snap  = 16'h0;
            m_an    = 4'hF;
            m_seg   = 7'h7F;
            m_dp    = 1'b1;
            for (int b = 0; b < 2; b++) begin
                m_stable[b] = 1'b0;
                m_armed[b]  = 1'b0;
                for (int k = 0; k <= DEB; k++) m_samp[b][k] = 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                acc[b] = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (m_samp[b][k] == m_stable[b]) acc[b] = 1'b0;
                pulse[b] = acc[b] && !m_stable[b] && m_armed[b];
                if (m_since >= 2 && !m_samp[b][1]) m_armed[b] = 1'b1;
                if (acc[b]) m_stable[b] = !m_stable[b];
                for (int k = DEB; k > 0; k--) m_samp[b][k] = m_samp[b][k-1];
                m_samp[b][0] = btn[b];
            end
            if (pulse[0] && !pulse[1])      m_show = m_show + 4'd1;
            else if (pulse[1] && !pulse[0]) m_show = m_show - 4'd1;
            idx   = (m_since / RD) % 4;
            m_an  = ~(4'b0001 << idx);
            m_seg = hex_tbl[m_snap[4*idx +: 4]];
            m_dp  = !(idx == 3 && bus.hold);
            if (!bus.hold) m_snap = bus.disp;
            m_since++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_show", bus.show, m_show);
            check("model_an",   bus.an,   m_an);
            check("model_seg",  bus.seg,  m_seg);
            check("model_dp",   bus.dp,   m_dp);
            check("one_anode",  ($countones(~bus.an) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit nxt, input bit prv, input int len);
        bus.btn_next = nxt;
        bus.btn_prev = prv;
        wait_cyc(len);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        wait_cyc(14);
    endtask

    initial begin
        bus.disp     = 16'h12AF;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.hold     = 1'b0;
        rst          = 1'b0;
        wait_cyc(2);
        check("rst_show", bus.show, 4'h0);
        check("rst_an",   bus.an,   4'hF);
        check("rst_seg",  bus.seg,  7'h7F);
        check("rst_dp",   bus.dp,   1'b1);
        rst = 1'b1;

        wait_cyc(2);
        for (int d = 0; d < 4; d++) begin
            check("scan_an",  bus.an,  an_lit[d]);
            check("scan_seg", bus.seg, seg_lit[d]);
            wait_cyc(4);
        end

        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 5);
        check("glitch_show", bus.show, 4'h0);
        press(1'b1, 1'b0, 20);
        check("held_show", bus.show, 4'h1);

        press(1'b0, 1'b1, 20);
        check("prev_to_0", bus.show, 4'h0);
        press(1'b0, 1'b1, 20);
        check("wrap_0_to_15", bus.show, 4'hF);
        press(1'b1, 1'b0, 20);
        check("wrap_15_to_0", bus.show, 4'h0);
        press(1'b0, 1'b1, 20);
        check("prev_wrap", bus.show, 4'hF);
        press(1'b1, 1'b1, 20);
        check("both_same", bus.show, 4'hF);

        bus.disp = 16'h0008;
        wait_cyc(2);
        bus.hold = 1'b1;
        bus.disp = 16'hFFFF;
        wait_cyc(2);
        for (int i = 0; i < 16; i++) begin
            check("hold_seg", bus.seg, (bus.an == 4'hE) ? 7'b0000000 : 7'b1000000);
            check("hold_dp",  bus.dp,  (bus.an == 4'h7) ? 1'b0 : 1'b1);
            wait_cyc(1);
        end
        bus.hold = 1'b0;
        wait_cyc(2);
        for (int i = 0; i < 16; i++) begin
            check("release_seg", bus.seg, 7'b0001110);
            wait_cyc(1);
        end

        while (((m_since + 7) / RD) % 4 != 2) wait_cyc(1);
        bus.btn_next = 1'b1;
        wait_cyc(7);
        rst = 1'b0;
        wait_cyc(1);
        check("midrst_an",   bus.an,   4'hF);
        check("midrst_show", bus.show, 4'h0);
        rst = 1'b1;
        wait_cyc(30);
        check("held_through_rst", bus.show, 4'h0);
        bus.btn_next = 1'b0;
        wait_cyc(14);
        press(1'b1, 1'b0, 20);
        check("repress_show", bus.show, 4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
